// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// -------------
// Sits between two byte producers, a TX FIFO and a UART transmitter.
//   * A write arbiter moves requester bytes into the FIFO. It grants at most
//     one write per cycle, combinationally, with the ack in the same cycle.
//   * A drain FSM pops one byte at a time from the FIFO. It hands the byte to
//     the transmitter, then waits for the busy high/low cycle before the next
//     byte.
//
// Configuration macro: UART_TX_SCHED_RR_EN
//   defined   -> round-robin between the two requesters.
//   undefined -> fixed priority, requester 0 always wins.
//
// Handshake: a requester raises i_reqN_valid with i_reqN_data and holds both
// stable until it sees o_reqN_ack high for one cycle. The byte is consumed in
// that same cycle. There is no other flow control.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req{0,1}_valid/data requester byte offer
//   o_req{0,1}_ack        one-cycle accept pulse
//   i_fifo_cnt            FIFO occupancy (registered, lags wr/rd by a cycle)
//   o_fifo_wr/o_fifo_wdata FIFO write strobe and byte
//   o_fifo_rd/i_fifo_rdata FIFO read strobe; data arrives the next cycle
//   o_tx_start/o_tx_data  start pulse and byte held for the transmitter
//   i_tx_busy             transmitter busy
//   o_busy                drain FSM not idle
//   o_dbg_state           drain FSM state
module uart_tx_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  output logic       o_req0_ack,
  output logic       o_req1_ack,
  input  logic [2:0] i_fifo_cnt,
  output logic       o_fifo_wr,
  output logic [7:0] o_fifo_wdata,
  output logic       o_fifo_rd,
  input  logic [7:0] i_fifo_rdata,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_busy,
  output logic       o_busy,
  output logic [2:0] o_dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_WAIT_LO = 3'd5;

  localparam logic [2:0] DEPTH_C  = 3'(FIFO_DEPTH);
  localparam logic [2:0] DEPTH_M1 = 3'(FIFO_DEPTH - 1);

  logic [2:0] state_q, state_d;
  logic [1:0] guard_q, guard_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       wr_q;
  logic       wr_ok;
  logic       grant0, grant1, grant;

  // i_fifo_cnt does not yet include a write granted last cycle. At one below
  // full, that write has filled the FIFO, so hold off for a cycle.
  assign wr_ok = !i_rst
              && (i_fifo_cnt < DEPTH_C)
              && (state_q != S_RD)
              && !(wr_q && (i_fifo_cnt == DEPTH_M1));

`ifdef UART_TX_SCHED_RR_EN
  logic rr_q;  // 1: requester 1 wins the next contention

  always_comb begin
    grant0 = wr_ok && i_req0_valid && (!i_req1_valid || !rr_q);
    grant1 = wr_ok && i_req1_valid && (!i_req0_valid || rr_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q <= 1'b0;
    end else if (grant0) begin
      rr_q <= 1'b1;
    end else if (grant1) begin
      rr_q <= 1'b0;
    end
  end
`else
  always_comb begin
    grant0 = wr_ok && i_req0_valid;
    grant1 = wr_ok && i_req1_valid && !i_req0_valid;
  end
`endif

  assign grant        = grant0 || grant1;
  assign o_req0_ack   = grant0;
  assign o_req1_ack   = grant1;
  assign o_fifo_wr    = grant;
  assign o_fifo_wdata = grant1 ? i_req1_data : i_req0_data;

  // Drain FSM
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    tx_data_d = tx_data_q;
    case (state_q)
      S_IDLE: begin
        // Never enter RD straight after a write grant, so a read strobe
        // never follows a write strobe back to back.
        if ((i_fifo_cnt != 3'd0) && !grant && !i_tx_busy) begin
          state_d = S_RD;
        end
      end
      S_RD: state_d = S_LOAD;
      S_LOAD: begin
        tx_data_d = i_fifo_rdata;
        state_d   = S_START;
      end
      S_START: begin
        guard_d = 2'd0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // Lost-start guard: give up after four cycles with no busy.
        if (i_tx_busy) begin
          guard_d = 2'd0;
          state_d = S_WAIT_LO;
        end else if (guard_q == 2'd3) begin
          guard_d = 2'd0;
          state_d = S_IDLE;
        end else begin
          guard_d = guard_q + 2'd1;
        end
      end
      S_WAIT_LO: begin
        if (!i_tx_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      guard_q   <= 2'd0;
      tx_data_q <= 8'h00;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      tx_data_q <= tx_data_d;
      wr_q      <= grant;
    end
  end

  // Strobes are masked while reset is high, because state_q is only cleared
  // at the edge.
  assign o_fifo_rd   = (state_q == S_RD) && !i_rst;
  assign o_tx_start  = (state_q == S_START) && !i_rst;
  assign o_busy      = (state_q != S_IDLE) && !i_rst;
  assign o_tx_data   = tx_data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ack, req1_ack;
  logic [2:0] fifo_cnt;
  logic       fifo_wr, fifo_rd;
  logic [7:0] fifo_wdata, fifo_rdata;
  logic       tx_start, tx_busy, busy;
  logic [7:0] tx_data;
  logic [2:0] dbg_state;

  uart_tx_sched #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req0_valid(req0_valid),
    .i_req0_data (req0_data),
    .i_req1_valid(req1_valid),
    .i_req1_data (req1_data),
    .o_req0_ack  (req0_ack),
    .o_req1_ack  (req1_ack),
    .i_fifo_cnt  (fifo_cnt),
    .o_fifo_wr   (fifo_wr),
    .o_fifo_wdata(fifo_wdata),
    .o_fifo_rd   (fifo_rd),
    .i_fifo_rdata(fifo_rdata),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .i_tx_busy   (tx_busy),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];   // bytes expected at the transmitter, in order

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every start pulse must carry the next expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got start with %02h expected none (t=%0t)", tx_data, $time);
        end else begin
          check8("tx_data", tx_data, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    next_cycle();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    fifo_cnt = 3'd0; tx_busy = 1'b0; fifo_rdata = 8'h00;
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- reference model (random phase) ----------------
  logic       m_r0v, m_r1v, gen_on;
  logic [7:0] m_r0d, m_r1d, m_rdata;
  logic [7:0] m_fifo[$];
  logic       m_busy, m_prev_g, m_pref1;
  int         m_wait, m_len;

  task automatic model_reset();
    m_r0v = 1'b0; m_r1v = 1'b0; m_r0d = 8'h00; m_r1d = 8'h00;
    m_rdata = 8'h00; m_fifo.delete(); m_busy = 1'b0;
    m_prev_g = 1'b0; m_pref1 = 1'b0; m_wait = 0; m_len = 0; gen_on = 1'b1;
  endtask

  task automatic drive_env();
    req0_valid = m_r0v; req0_data = m_r0d;
    req1_valid = m_r1v; req1_data = m_r1d;
    fifo_cnt   = 3'(m_fifo.size());
    fifo_rdata = m_rdata;
    tx_busy    = m_busy;
  endtask

  task automatic ref_step();
    logic allowed, e0, e1;
    int   cnt;
    cnt = int'(fifo_cnt);
    // A write is allowed below full, never alongside a read, and never
    // right after a write that filled the FIFO's last slot.
    allowed = (cnt < DEPTH) && !fifo_rd && !(m_prev_g && cnt == DEPTH - 1);
    e0 = 1'b0; e1 = 1'b0;
    if (allowed) begin
      if (m_r0v && m_r1v) begin
`ifdef UART_TX_SCHED_RR_EN
        if (m_pref1) e1 = 1'b1; else e0 = 1'b1;
`else
        e0 = 1'b1;
`endif
      end else if (m_r0v) begin
        e0 = 1'b1;
      end else if (m_r1v) begin
        e1 = 1'b1;
      end
    end
    check1("ack0", req0_ack, e0);
    check1("ack1", req1_ack, e1);
    check1("fifo_wr", fifo_wr, e0 | e1);
    if (e0 | e1) begin
      check8("fifo_wdata", fifo_wdata, e1 ? m_r1d : m_r0d);
      exp_q.push_back(e1 ? m_r1d : m_r0d);
    end
    if (fifo_rd) begin
      check1("rd_nonempty", logic'(cnt != 0), 1'b1);
      check1("rd_after_wr", m_prev_g, 1'b0);
    end
    if (e0) begin m_r0v = 1'b0; m_pref1 = 1'b1; end
    if (e1) begin m_r1v = 1'b0; m_pref1 = 1'b0; end
    m_prev_g = e0 | e1;
    // FIFO model
    if (fifo_wr) m_fifo.push_back(fifo_wdata);
    if (fifo_rd && m_fifo.size() > 0) m_rdata = m_fifo.pop_front();
    // Transmitter model: busy rises after 0..2 cycles for 1..6 cycles,
    // or occasionally never rises at all.
    if (tx_start) begin
      m_wait = $urandom_range(0, 2);
      m_len  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
    end
    if (m_wait > 0) begin
      m_busy = 1'b0; m_wait--;
    end else if (m_len > 0) begin
      m_busy = 1'b1; m_len--;
    end else begin
      m_busy = 1'b0;
    end
    // Requesters
    if (gen_on && !m_r0v && $urandom_range(0, 1) == 1) begin
      m_r0v = 1'b1; m_r0d = 8'($urandom_range(0, 255));
    end
    if (gen_on && !m_r1v && $urandom_range(0, 2) == 0) begin
      m_r1v = 1'b1; m_r1d = 8'($urandom_range(0, 255));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] pat0, pat1;

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 8'hAA;
    req1_valid = 1'b0; req1_data = 8'h00;
    fifo_cnt = 3'd0; fifo_rdata = 8'h00; tx_busy = 1'b0;
    model_reset();

    // Reset: strobes masked even with a requester valid
    @(negedge clk);
    check1("rst_wr", fifo_wr, 1'b0);
    check1("rst_ack0", req0_ack, 1'b0);
    check1("rst_busy", busy, 1'b0);
    next_cycle();
    @(negedge clk);
    check8("rst_tx_data", tx_data, 8'h00);
    check1("rst_rd", fifo_rd, 1'b0);
    check1("rst_start", tx_start, 1'b0);

    // Single write, then read two cycles later, then lost-start guard
    next_cycle();
    rst = 1'b0; req0_valid = 1'b1; req0_data = 8'h31; fifo_cnt = 3'd0;
    exp_q.push_back(8'h31);
    @(negedge clk);
    check1("t1_wr", fifo_wr, 1'b1);
    check1("t1_ack0", req0_ack, 1'b1);
    check1("t1_ack1", req1_ack, 1'b0);
    check8("t1_wdata", fifo_wdata, 8'h31);
    next_cycle();
    req0_valid = 1'b0; fifo_cnt = 3'd1;
    @(negedge clk);
    check1("t1_idle_rd", fifo_rd, 1'b0);
    check1("t1_idle_busy", busy, 1'b0);
    next_cycle();
    @(negedge clk);
    check1("t1_rd", fifo_rd, 1'b1);
    check1("t1_rd_busy", busy, 1'b1);
    next_cycle();
    fifo_cnt = 3'd0; fifo_rdata = 8'h31;
    @(negedge clk);
    check1("t1_load_rd", fifo_rd, 1'b0);
    next_cycle();
    @(negedge clk);
    check1("t1_start", tx_start, 1'b1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      check1("t1_wait_hi_busy", busy, 1'b1);
      check1("t1_wait_hi_start", tx_start, 1'b0);
    end
    next_cycle();
    @(negedge clk);
    check1("t1_guard_idle", busy, 1'b0);

    // Contention between both requesters
`ifdef UART_TX_SCHED_RR_EN
    pat0 = 3'b101; pat1 = 3'b010;
`else
    pat0 = 3'b111; pat1 = 3'b000;
`endif
    apply_reset();
    req0_valid = 1'b1; req0_data = 8'h41;
    req1_valid = 1'b1; req1_data = 8'h42;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check1("t2_ack0", req0_ack, pat0[k]);
      check1("t2_ack1", req1_ack, pat1[k]);
      check8("t2_wdata", fifo_wdata, pat1[k] ? 8'h42 : 8'h41);
      next_cycle();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // One below full: one write, blocked next cycle, then full
    apply_reset();
    tx_busy = 1'b1; fifo_cnt = 3'd3; req0_valid = 1'b1; req0_data = 8'h55;
    @(negedge clk);
    check1("t3_wr", fifo_wr, 1'b1);
    check1("t3_ack0", req0_ack, 1'b1);
    next_cycle();
    @(negedge clk);
    check1("t3_inflight_wr", fifo_wr, 1'b0);
    check1("t3_inflight_ack", req0_ack, 1'b0);
    next_cycle();
    fifo_cnt = 3'd4;
    @(negedge clk);
    check1("t3_full_ack", req0_ack, 1'b0);
    check1("t3_full_wr", fifo_wr, 1'b0);
    next_cycle();
    req0_valid = 1'b0; tx_busy = 1'b0; fifo_cnt = 3'd0;

    // Full transfer with a 10-cycle busy window
    apply_reset();
    fifo_cnt = 3'd2;
    @(negedge clk);
    check1("t4_idle_rd", fifo_rd, 1'b0);
    next_cycle();
    @(negedge clk);
    check1("t4_rd", fifo_rd, 1'b1);
    next_cycle();
    fifo_rdata = 8'h35; fifo_cnt = 3'd0;
    exp_q.push_back(8'h35);
    @(negedge clk);
    check1("t4_load_start", tx_start, 1'b0);
    next_cycle();
    @(negedge clk);
    check1("t4_start", tx_start, 1'b1);
    next_cycle();
    tx_busy = 1'b1;
    @(negedge clk);
    check1("t4_wait_hi_busy", busy, 1'b1);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      tx_busy = (i < 9);
      @(negedge clk);
      check1("t4_wait_lo_busy", busy, 1'b1);
      check8("t4_tx_hold", tx_data, 8'h35);
    end
    next_cycle();
    @(negedge clk);
    check1("t4_done_idle", busy, 1'b0);
    check1("t4_done_rd", fifo_rd, 1'b0);

    // Reset while waiting for busy to drop
    next_cycle();
    fifo_cnt = 3'd1;
    next_cycle();
    @(negedge clk);
    check1("t5_rd", fifo_rd, 1'b1);
    next_cycle();
    fifo_rdata = 8'h77; fifo_cnt = 3'd0;
    exp_q.push_back(8'h77);
    next_cycle();
    @(negedge clk);
    check1("t5_start", tx_start, 1'b1);
    next_cycle();
    tx_busy = 1'b1;
    next_cycle();
    @(negedge clk);
    check1("t5_wait_lo_busy", busy, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check1("t5_rst_busy", busy, 1'b0);
    check1("t5_rst_start", tx_start, 1'b0);
    check1("t5_rst_rd", fifo_rd, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check1("t5_post_busy", busy, 1'b0);
    check8("t5_post_tx_data", tx_data, 8'h00);
    check1("t5_post_start", tx_start, 1'b0);
    next_cycle();
    tx_busy = 1'b0;
    check1("t5_exp_empty", logic'(exp_q.size() == 0), 1'b1);
    exp_q.delete();

    // Randomized traffic against the reference model
    apply_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      drive_env();
      @(negedge clk);
      ref_step();
      next_cycle();
    end
    gen_on = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (exp_q.size() == 0 && m_fifo.size() == 0 && !m_r0v && !m_r1v) break;
      drive_env();
      @(negedge clk);
      ref_step();
      next_cycle();
    end
    check1("drain_done",
           logic'(exp_q.size() == 0 && m_fifo.size() == 0 && !m_r0v && !m_r1v), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
